// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_bridge
// Description : Bridges single-beat CPU memory requests onto a req/gnt/rvalid
//               bus with alignment checks and a per-phase timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_be,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] WAIT_R = 3'd2;
    localparam logic [2:0] RESP   = 3'd3;
    localparam logic [2:0] ERR    = 3'd4;

    // Counter value seen during the last permitted wait cycle of a phase.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [15:0] cnt;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic [31:0] rdata_q;

    logic        any_req;
    logic        bad_req;

    assign any_req = mem_read | mem_write;
    assign bad_req = (mem_read & mem_write)
                   | (mem_be == 4'h0)
                   | ((mem_be == 4'hF) && (mem_addr[1:0] != 2'b00));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = bad_req ? ERR : REQ;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    state_next = we_q ? RESP : WAIT_R;
                end else if (cnt == CNT_LAST) begin
                    state_next = ERR;
                end
            end
            WAIT_R: begin
                if (bus_rvalid) begin
                    state_next = RESP;
                end else if (cnt == CNT_LAST) begin
                    state_next = ERR;
                end
            end
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            addr_q  <= 30'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    cnt <= 16'd0;
                    // Rejected requests leave the bus-side registers untouched.
                    if (any_req && !bad_req) begin
                        addr_q  <= mem_addr[31:2];
                        wdata_q <= mem_wdata;
                        be_q    <= mem_be;
                        we_q    <= mem_write;
                    end
                end
                REQ: begin
                    cnt <= bus_gnt ? 16'd0 : cnt + 16'd1;
                end
                WAIT_R: begin
                    cnt <= cnt + 16'd1;
                    if (bus_rvalid) begin
                        rdata_q <= bus_rdata;
                    end
                end
                default: cnt <= 16'd0;
            endcase
        end
    end

    assign bus_req   = (state == REQ);
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q, 2'b00};
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;
    assign mem_resp  = (state == RESP) || (state == ERR);
    assign mem_err   = (state == ERR);
    assign mem_rdata = rdata_q;

endmodule
`default_nettype wire
